regfile_mp_bypass: RTL

- Parametrised successor of the 64-bit, 32-entry register file.
- Depth, data width and read-port count are parameters; the zero register is configurable.
- Adds same-cycle write-to-read bypass and a per-register busy scoreboard that the pipeline uses to stall on outstanding load destinations.
- Sits between decode (read and scoreboard check) and writeback (write and busy clear).

---
 rtl/regfile_mp_bypass_pkg.sv | 17 +
 rtl/regfile_mp_bypass_if.sv | 31 +++
 rtl/regfile_mp_bypass_scoreboard.sv | 60 ++++++
 rtl/regfile_mp_bypass.sv | 65 ++++++
 4 files changed

// File: rtl/regfile_mp_bypass_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_pkg
//  Brief    : Shared constants and types for the bypassing register file.
//  Revision : 1.0
// ============================================================================
package regfile_pkg;

    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 5;
    localparam int ZERO_REG = 31;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

endpackage
`default_nettype wire

// File: rtl/regfile_mp_bypass_if.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_mp_bypass_if
//  Brief    : Decode/writeback-side bus of the register file (write, reads, busy).
//  Revision : 1.0
// ============================================================================
interface regfile_mp_bypass_if #(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W,
    parameter int NUM_RD = 2
);
    logic                     RegWrite;
    logic [ADDR_W-1:0]        WriteRegister;
    logic [DATA_W-1:0]        WriteData;
    logic [NUM_RD*ADDR_W-1:0] ReadRegister;
    logic [NUM_RD*DATA_W-1:0] ReadData;
    logic                     BusySet;
    logic [ADDR_W-1:0]        BusyAddr;
    logic [NUM_RD-1:0]        ReadBusy;

    modport master (
        output RegWrite, WriteRegister, WriteData, ReadRegister, BusySet, BusyAddr,
        input  ReadData, ReadBusy
    );

    modport slave (
        input  RegWrite, WriteRegister, WriteData, ReadRegister, BusySet, BusyAddr,
        output ReadData, ReadBusy
    );
endinterface
`default_nettype wire

// File: rtl/regfile_mp_bypass_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_scoreboard
//  Brief    : Per-register busy bits with set-over-clear priority and per-port lookup.
//  Revision : 1.0
// ============================================================================
module regfile_scoreboard #(
    parameter int ADDR_W    = regfile_pkg::ADDR_W,
    parameter int NUM_RD    = 2,
    parameter int ZERO_REG  = regfile_pkg::ZERO_REG,
    parameter int BYPASS_EN = 1
) (
    input  wire logic                     clk,
    input  wire logic                     reset_n,
    input  wire logic                     i_set_en,
    input  wire logic [ADDR_W-1:0]        i_set_addr,
    input  wire logic                     i_clr_en,
    input  wire logic [ADDR_W-1:0]        i_clr_addr,
    input  wire logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
    output logic      [NUM_RD-1:0]        o_rd_busy
);
    import regfile_pkg::*;

    localparam int                NUM_REGS    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] c_ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_nxt;

    // Set is applied after clear: a load issued behind a completing write keeps the register pending.
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_clr_en) begin
            w_busy_nxt[i_clr_addr] = 1'b0;
        end
        if (i_set_en && (i_set_addr != c_ZERO_ADDR)) begin
            w_busy_nxt[i_set_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_busy
        logic [ADDR_W-1:0] w_addr;
        logic              w_fwd;

        assign w_addr = i_rd_addr[i*ADDR_W +: ADDR_W];
        // A forwarded write satisfies the pending load, so no stall is needed.
        assign w_fwd  = (BYPASS_EN != 0) && i_clr_en && (i_clr_addr == w_addr);
        assign o_rd_busy[i] = r_busy[w_addr] && (w_addr != c_ZERO_ADDR) && !w_fwd;
    end

endmodule
`default_nettype wire

// File: rtl/regfile_mp_bypass.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_mp_bypass
//  Brief    : Multi-port register file with write-to-read bypass and load scoreboard.
//  Revision : 1.0
// ============================================================================
module regfile_mp_bypass #(
    parameter int DATA_W    = regfile_pkg::DATA_W,
    parameter int ADDR_W    = regfile_pkg::ADDR_W,
    parameter int NUM_RD    = 2,
    parameter int ZERO_REG  = regfile_pkg::ZERO_REG,
    parameter int BYPASS_EN = 1
) (
    input  wire logic           clk,
    input  wire logic           reset_n,
    regfile_mp_bypass_if.slave  bus
);
    import regfile_pkg::*;

    localparam int                NUM_REGS    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] c_ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] r_mem [NUM_REGS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                r_mem[k] <= '0;
            end
        end else if (bus.RegWrite && (bus.WriteRegister != c_ZERO_ADDR)) begin
            r_mem[bus.WriteRegister] <= bus.WriteData;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic              w_hit;

        assign w_addr = bus.ReadRegister[i*ADDR_W +: ADDR_W];
        assign w_hit  = (BYPASS_EN != 0) && bus.RegWrite && (bus.WriteRegister == w_addr);
        // Reset gates the bypass path too, so outputs are zero for the whole reset window.
        assign bus.ReadData[i*DATA_W +: DATA_W] =
            (!reset_n || (w_addr == c_ZERO_ADDR)) ? '0 :
            w_hit                                 ? bus.WriteData :
                                                    r_mem[w_addr];
    end

    regfile_scoreboard #(
        .ADDR_W    (ADDR_W),
        .NUM_RD    (NUM_RD),
        .ZERO_REG  (ZERO_REG),
        .BYPASS_EN (BYPASS_EN)
    ) u_scoreboard (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_set_en   (bus.BusySet),
        .i_set_addr (bus.BusyAddr),
        .i_clr_en   (bus.RegWrite),
        .i_clr_addr (bus.WriteRegister),
        .i_rd_addr  (bus.ReadRegister),
        .o_rd_busy  (bus.ReadBusy)
    );

endmodule
`default_nettype wire
